// File: rtl/exa_vc_traffic_gen.sv
// AXI-Stream packet generator that steers each packet to a virtual channel,
// picked either as a fixed VC or round-robin over VCs whose s2e FIFO is not full.
`timescale 1ns/1ps
module exa_vc_traffic_gen #(
  parameter int DATA_W   = 128,
  parameter int PRIO_NUM = 2,
  parameter int VC_NUM   = 2,
  parameter int LEN_W    = 16,
  parameter int GAP_W    = 8,
  localparam int NVC     = PRIO_NUM * VC_NUM,
  localparam int VCW     = (NVC > 1) ? $clog2(NVC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic [LEN_W-1:0]  i_num_of_words,
  input  logic [GAP_W-1:0]  i_gap_cycles,
  input  logic              i_vc_mode,
  input  logic [VCW-1:0]    i_fixed_vc,
  input  logic [NVC-1:0]    i_fifo_full,
  output logic [VCW-1:0]    o_output_vc,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [31:0]       o_pkt_count,
  output logic              o_stall
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SEND, S_GAP} state_t;

  state_t           r_state, w_next;
  logic [VCW-1:0]   r_vc, r_rr_ptr, w_sel_vc, w_idx;
  logic             w_sel_ok, w_start, w_hs, w_last;
  logic [LEN_W-1:0] r_len, r_word_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [31:0]      r_pkt_count;
  logic [15:0]      r_seq;
  logic [63:0]      w_hdr;

  // Eligible VC: fixed target, or first non-full VC after the RR pointer.
  always_comb begin
    w_sel_ok = 1'b0;
    w_sel_vc = '0;
    w_idx    = '0;
    if (!i_vc_mode) begin
      w_sel_vc = i_fixed_vc;
      if (32'(i_fixed_vc) < 32'(NVC)) w_sel_ok = !i_fifo_full[i_fixed_vc];
    end else begin
      for (int unsigned i = 1; i <= NVC; i++) begin
        w_idx = VCW'((32'(r_rr_ptr) + i) % NVC);
        if (!w_sel_ok && !i_fifo_full[w_idx]) begin
          w_sel_ok = 1'b1;
          w_sel_vc = w_idx;
        end
      end
    end
  end

  assign w_start = (r_state == S_SELECT) && i_enable && w_sel_ok;
  assign w_hs    = (r_state == S_SEND) && m_axis_tready;
  assign w_last  = (r_word_idx == r_len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_enable) w_next = S_SELECT;
      S_SELECT: begin
        if (!i_enable)    w_next = S_IDLE;
        else if (w_sel_ok) w_next = S_SEND;
      end
      S_SEND: begin
        if (w_hs && w_last) begin
          if (i_gap_cycles != '0) w_next = S_GAP;
          else if (i_enable)      w_next = S_SELECT;
          else                    w_next = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) w_next = i_enable ? S_SELECT : S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vc        <= '0;
      r_rr_ptr    <= VCW'(NVC - 1);
      r_len       <= LEN_W'(1);
      r_word_idx  <= '0;
      r_gap_cnt   <= '0;
      r_pkt_count <= '0;
      r_seq       <= '0;
    end else begin
      if (w_start) begin
        r_vc       <= w_sel_vc;
        if (i_vc_mode) r_rr_ptr <= w_sel_vc;
        r_len      <= (i_num_of_words == '0) ? LEN_W'(1) : i_num_of_words;
        r_word_idx <= '0;
        r_seq      <= r_pkt_count[15:0];
      end
      if (w_hs) begin
        if (w_last) begin
          r_pkt_count <= r_pkt_count + 32'd1;
          r_gap_cnt   <= i_gap_cycles;
        end else begin
          r_word_idx  <= r_word_idx + LEN_W'(1);
        end
      end
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end

  assign w_hdr = {24'hE7A000, 8'(r_vc), r_seq, 16'(r_word_idx)};

  always_comb begin
    m_axis_tvalid = (r_state == S_SEND);
    m_axis_tlast  = (r_state == S_SEND) && w_last;
    m_axis_tdata  = (r_state == S_SEND) ? DATA_W'(w_hdr) : '0;
    o_stall       = (r_state == S_SELECT) && !w_sel_ok;
    o_output_vc   = r_vc;
    o_pkt_count   = r_pkt_count;
  end

endmodule

// File: tb/tb_exa_vc_traffic_gen.sv
// Directed bench for exa_vc_traffic_gen: table of packets plus hand sequences
// for stall, backpressure, gap and mid-packet reset.
`timescale 1ns/1ps
module tb_exa_vc_traffic_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_enable;
  logic [15:0]  i_num_of_words;
  logic [7:0]   i_gap_cycles;
  logic         i_vc_mode;
  logic [1:0]   i_fixed_vc;
  logic [3:0]   i_fifo_full;
  logic [1:0]   o_output_vc;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [31:0]  o_pkt_count;
  logic         o_stall;

  exa_vc_traffic_gen #(.DATA_W(128), .PRIO_NUM(2), .VC_NUM(2), .LEN_W(16), .GAP_W(8)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_num_of_words(i_num_of_words),
    .i_gap_cycles(i_gap_cycles), .i_vc_mode(i_vc_mode), .i_fixed_vc(i_fixed_vc),
    .i_fifo_full(i_fifo_full), .o_output_vc(o_output_vc), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .o_pkt_count(o_pkt_count), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mode;
    logic [1:0]  fvc;
    logic [3:0]  full;
    logic [15:0] words;
    logic [1:0]  exp_vc;
    int          exp_len;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(output int idle);
    idle = 0;
    forever begin
      @(negedge clk);
      if (m_axis_tvalid) return;
      idle++;
      if (idle > 200) begin
        checks++;
        errors++;
        $display("FAIL wait_valid: tvalid never rose after %0d cycles", idle);
        return;
      end
    end
  endtask

  task automatic apply(input vec_t v);
    i_vc_mode      = v.mode;
    i_fixed_vc     = v.fvc;
    i_fifo_full    = v.full;
    i_num_of_words = v.words;
  endtask

  task automatic do_reset();
    i_enable = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
  endtask

  task automatic check_beat(input int b, input int seq, input logic [1:0] vc, input int len);
    chk("tvalid", m_axis_tvalid, 1);
    chk("word_idx", m_axis_tdata[15:0], b);
    chk("seq", m_axis_tdata[31:16], seq);
    chk("vc_field", m_axis_tdata[39:32], vc);
    chk("magic", m_axis_tdata[63:40], 24'hE7A000);
    chk("upper_zero", m_axis_tdata[127:64], 0);
    chk("output_vc", o_output_vc, vc);
    chk("tlast", m_axis_tlast, (b == len - 1));
  endtask

  initial begin
    int idle, beats, accepted, c;
    logic done, have_prev, tr, prev_last;
    logic [127:0] prev_data;
    logic [1:0] prev_vc;

    reset = 1'b1; i_enable = 1'b0; i_num_of_words = '0; i_gap_cycles = '0;
    i_vc_mode = 1'b0; i_fixed_vc = '0; i_fifo_full = '0; m_axis_tready = 1'b1;

    // RR part first (pointer starts fresh), fixed-mode entries afterwards.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 2'd0, 4'b0000, 16'd3, 2'(i % 4), 3};
    tbl[5]  = '{1'b1, 2'd0, 4'b0010, 16'd2, 2'd2, 2};
    tbl[6]  = '{1'b1, 2'd0, 4'b0010, 16'd2, 2'd3, 2};
    tbl[7]  = '{1'b1, 2'd0, 4'b0010, 16'd2, 2'd0, 2};
    tbl[8]  = '{1'b1, 2'd0, 4'b0010, 16'd2, 2'd2, 2};
    tbl[9]  = '{1'b0, 2'd2, 4'b0000, 16'd18, 2'd2, 18};
    tbl[10] = '{1'b0, 2'd1, 4'b0000, 16'd0, 2'd1, 1};
    tbl[11] = '{1'b0, 2'd3, 4'b0100, 16'd5, 2'd3, 5};

    repeat (2) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_vc", o_output_vc, 0);
    chk("rst_pkt_count", o_pkt_count, 0);
    chk("rst_stall", o_stall, 0);
    reset = 1'b0;

    // Table-driven back-to-back packets, gap=0, tready=1.
    apply(tbl[0]);
    i_gap_cycles = 8'd0;
    i_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_valid(idle);
      chk("idle_before_pkt", idle, 1);
      chk("vc_not_full", i_fifo_full[o_output_vc], 0);
      beats = 0;
      done = 1'b0;
      while (!done && beats < 40) begin
        check_beat(beats, i, tbl[i].exp_vc, tbl[i].exp_len);
        if (m_axis_tlast) begin
          done = 1'b1;
          if (i < 11) apply(tbl[i + 1]);
          else i_enable = 1'b0;
        end
        beats++;
        if (!done) @(negedge clk);
      end
      chk("pkt_len", beats, tbl[i].exp_len);
    end
    @(negedge clk);
    chk("table_pkt_count", o_pkt_count, 12);
    chk("table_idle_after", m_axis_tvalid, 0);

    // All VCs full: stall in SELECT until one flag clears.
    do_reset();
    i_vc_mode = 1'b1; i_fifo_full = 4'b1111; i_num_of_words = 16'd1;
    i_gap_cycles = 8'd0; m_axis_tready = 1'b1; i_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_flag", o_stall, 1);
      chk("stall_tvalid", m_axis_tvalid, 0);
    end
    i_fifo_full = 4'b1011;
    @(negedge clk);
    chk("unstall_tvalid", m_axis_tvalid, 1);
    chk("unstall_vc", o_output_vc, 2);
    chk("unstall_stall", o_stall, 0);
    chk("unstall_tlast", m_axis_tlast, 1);
    i_enable = 1'b0;
    @(negedge clk);
    chk("unstall_done_tvalid", m_axis_tvalid, 0);
    chk("unstall_pkt_count", o_pkt_count, 1);

    // Backpressure with tready 1,0,0,1,... and a full flag raised mid-packet.
    do_reset();
    i_vc_mode = 1'b0; i_fixed_vc = 2'd1; i_fifo_full = 4'b0000;
    i_num_of_words = 16'd4; i_gap_cycles = 8'd0; i_enable = 1'b1;
    wait_valid(idle);
    i_enable = 1'b0;
    accepted = 0; have_prev = 1'b0; c = 0;
    while (c < 60) begin
      tr = (c % 4 == 0) || (c % 4 == 3);
      if (have_prev) begin
        chk("bp_hold_data", m_axis_tdata, prev_data);
        chk("bp_hold_last", m_axis_tlast, prev_last);
        chk("bp_hold_vc", o_output_vc, prev_vc);
      end
      chk("bp_tvalid", m_axis_tvalid, 1);
      chk("bp_word", m_axis_tdata[15:0], accepted);
      chk("bp_tlast", m_axis_tlast, (accepted == 3));
      if (c == 1) i_fifo_full = 4'b0010;
      m_axis_tready = tr;
      if (tr) begin
        accepted++;
        have_prev = 1'b0;
        if (m_axis_tlast) break;
      end else begin
        have_prev = 1'b1;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        prev_vc   = o_output_vc;
      end
      c++;
      @(negedge clk);
    end
    chk("bp_accepted", accepted, 4);
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("bp_after_tvalid", m_axis_tvalid, 0);
    chk("bp_pkt_count", o_pkt_count, 1);

    // len=0 gives one-beat packets; gap=5 then the SELECT cycle before the next.
    do_reset();
    i_fifo_full = 4'b0000; i_fixed_vc = 2'd0; i_num_of_words = 16'd0;
    i_gap_cycles = 8'd5; i_enable = 1'b1;
    wait_valid(idle);
    chk("len0_tlast", m_axis_tlast, 1);
    chk("len0_word", m_axis_tdata[15:0], 0);
    wait_valid(idle);
    chk("gap_idle_cycles", idle, 6);
    chk("gap_pkt_count", o_pkt_count, 1);
    chk("gap_seq", m_axis_tdata[31:16], 1);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);

    // Reset on beat 3 of a 10-word packet aborts it.
    do_reset();
    i_vc_mode = 1'b1; i_fifo_full = 4'b0000; i_num_of_words = 16'd1;
    i_gap_cycles = 8'd0; i_enable = 1'b1;
    wait_valid(idle);
    chk("rp_first_vc", o_output_vc, 0);
    i_num_of_words = 16'd10;
    wait_valid(idle);
    chk("rp_second_vc", o_output_vc, 1);
    repeat (2) @(negedge clk);
    chk("rp_beat3_word", m_axis_tdata[15:0], 2);
    reset = 1'b1;
    @(negedge clk);
    chk("rp_tvalid", m_axis_tvalid, 0);
    chk("rp_tlast", m_axis_tlast, 0);
    chk("rp_tdata", m_axis_tdata, 0);
    chk("rp_vc", o_output_vc, 0);
    chk("rp_pkt_count", o_pkt_count, 0);
    chk("rp_stall", o_stall, 0);
    reset = 1'b0;
    wait_valid(idle);
    chk("rp_restart_idle", idle, 1);
    chk("rp_restart_word", m_axis_tdata[15:0], 0);
    chk("rp_restart_vc", o_output_vc, 0);
    chk("rp_restart_seq", m_axis_tdata[31:16], 0);
    i_enable = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
